// File: rtl/sram_mem_ctrl_if.sv
// Pipeline-side and SRAM-side signal bundle for sram_mem_ctrl.
//   slave  : controller view (requests and SRAM read data in; result, ready, SRAM pins out)
//   master : pipeline / SRAM-pad view (the mirror image)
// ready is combinational inside the controller; every other controller output is registered.
interface sram_mem_ctrl_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [16:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller for a 16-bit asynchronous SRAM.
// Each 32-bit load/store becomes two 16-bit accesses (low half, then high half),
// each lasting WAIT_CYCLES+1 cycles. ready is the pipeline stage-register enable.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - sram_mem_ctrl_if.slave: rd_en/wr_en/address/write_data in,
//          read_data/ready out, sram_addr/sram_dq_out/sram_dq_oe/sram_we_n out,
//          sram_dq_in in
// Parameter: WAIT_CYCLES (0..7) extra wait cycles per half.
// Optional feature macro: SRAM_CTRL_READ_HIT_EN - single-entry load tag; a repeat
// load of the last loaded word completes in the request cycle without an SRAM access.
module sram_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  sram_mem_ctrl_if.slave bus
);

  localparam int unsigned AW = 17;
  localparam int unsigned HW = 16;
  localparam int unsigned TW = 16;
  localparam logic [2:0]  WCNT_LAST = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      wcnt_q, wcnt_d;
  logic            is_store_q, is_store_d;
  logic [31:0]     read_data_q, read_data_d;
  logic [AW-1:0]   sram_addr_q, sram_addr_d;
  logic [HW-1:0]   sram_dq_out_q, sram_dq_out_d;
  logic            sram_dq_oe_q, sram_dq_oe_d;
  logic            sram_we_n_q, sram_we_n_d;

  logic            req_c;
  logic            last_c;
  logic            hit_c;
  logic            drive_c;
  logic            drive_hi_c;
  logic            ready_c;
  logic [TW-1:0]   tag_c;
  logic            unused_addr_c;

  assign req_c  = bus.rd_en | bus.wr_en;
  assign last_c = (wcnt_q == WCNT_LAST);
  assign tag_c  = bus.address[17:2];
  assign unused_addr_c = ^{bus.address[31:18], bus.address[1:0]};

`ifdef SRAM_CTRL_READ_HIT_EN
  logic [TW-1:0] last_addr_q, last_addr_d;
  logic          last_valid_q, last_valid_d;

  // Load-only hit: a simultaneous store request always wins.
  assign hit_c = (state_q == IDLE) && bus.rd_en && !bus.wr_en &&
                 last_valid_q && (tag_c == last_addr_q);
`else
  assign hit_c = 1'b0;
`endif

  // Next-state, load capture and next values of the SRAM pins.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    is_store_d  = is_store_q;
    read_data_d = read_data_q;
    ready_c     = 1'b0;
    drive_c     = 1'b0;
    drive_hi_c  = 1'b0;
`ifdef SRAM_CTRL_READ_HIT_EN
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;
`endif

    case (state_q)
      IDLE: begin
        ready_c = !req_c || hit_c;
        if (req_c && !hit_c) begin
          state_d    = LOW;
          wcnt_d     = '0;
          is_store_d = bus.wr_en;
          drive_c    = 1'b1;
`ifdef SRAM_CTRL_READ_HIT_EN
          if (bus.wr_en) last_valid_d = 1'b0;
`endif
        end
      end
      LOW: begin
        drive_c = 1'b1;
        if (last_c) begin
          state_d    = HIGH;
          wcnt_d     = '0;
          drive_hi_c = 1'b1;
          if (!is_store_q) read_data_d[15:0] = bus.sram_dq_in;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      HIGH: begin
        if (last_c) begin
          state_d = DONE;
          wcnt_d  = '0;
          if (!is_store_q) read_data_d[31:16] = bus.sram_dq_in;
        end else begin
          wcnt_d     = wcnt_q + 3'd1;
          drive_c    = 1'b1;
          drive_hi_c = 1'b1;
        end
      end
      DONE: begin
        // A request still present here is the one just served; it is not restarted.
        ready_c = 1'b1;
        state_d = IDLE;
`ifdef SRAM_CTRL_READ_HIT_EN
        if (!is_store_q) begin
          last_valid_d = 1'b1;
          last_addr_d  = tag_c;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // SRAM pins are registered from the state being entered; idle value is all-zero / inactive.
    sram_addr_d   = drive_c ? {tag_c, drive_hi_c} : '0;
    sram_we_n_d   = !(drive_c && is_store_d);
    sram_dq_oe_d  = drive_c && is_store_d;
    sram_dq_out_d = (drive_c && is_store_d) ?
                    (drive_hi_c ? bus.write_data[31:16] : bus.write_data[15:0]) : '0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      is_store_q    <= 1'b0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      is_store_q    <= is_store_d;
      read_data_q   <= read_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
    end
  end

`ifdef SRAM_CTRL_READ_HIT_EN
  // Single-entry load tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
    end
  end
`endif

  assign bus.ready       = ready_c;
  assign bus.read_data   = read_data_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_dq_out = sram_dq_out_q;
  assign bus.sram_dq_oe  = sram_dq_oe_q;
  assign bus.sram_we_n   = sram_we_n_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: one instance with WAIT_CYCLES=0 (index 0) and one with
// WAIT_CYCLES=1 (index 1), each with its own behavioural 16-bit SRAM.
module tb_sram_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_mem_ctrl_if if0();
  sram_mem_ctrl_if if1();

  sram_mem_ctrl #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  sram_mem_ctrl #(.WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Index-addressable views of both instances.
  logic        rd_drv [2];
  logic        wr_drv [2];
  logic [31:0] addr_drv [2];
  logic [31:0] wd_drv [2];
  logic        rdy [2];
  logic [31:0] rdat [2];
  logic [16:0] sadr [2];
  logic [15:0] sdo [2];
  logic        soe [2];
  logic        swe [2];
  logic [15:0] mem [2][256];

  assign if0.rd_en = rd_drv[0];   assign if1.rd_en = rd_drv[1];
  assign if0.wr_en = wr_drv[0];   assign if1.wr_en = wr_drv[1];
  assign if0.address = addr_drv[0]; assign if1.address = addr_drv[1];
  assign if0.write_data = wd_drv[0]; assign if1.write_data = wd_drv[1];
  assign rdy[0] = if0.ready;      assign rdy[1] = if1.ready;
  assign rdat[0] = if0.read_data; assign rdat[1] = if1.read_data;
  assign sadr[0] = if0.sram_addr; assign sadr[1] = if1.sram_addr;
  assign sdo[0] = if0.sram_dq_out; assign sdo[1] = if1.sram_dq_out;
  assign soe[0] = if0.sram_dq_oe; assign soe[1] = if1.sram_dq_oe;
  assign swe[0] = if0.sram_we_n;  assign swe[1] = if1.sram_we_n;
  assign if0.sram_dq_in = mem[0][sadr[0][7:0]];
  assign if1.sram_dq_in = mem[1][sadr[1][7:0]];

  // Behavioural SRAM: async read, write while we_n is low; preset 0xDEADBEEF at byte 0x10.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= 16'h0000;
        mem[k][8] <= 16'hBEEF;
        mem[k][9] <= 16'hDEAD;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (!swe[k]) mem[k][sadr[k][7:0]] <= sdo[k];
    end
  end

  typedef struct {
    int unsigned dut;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_rd [2];
  logic [31:0] sb_q [$];
  vec_t        vecs [11];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs one access cycle by cycle, checking ready and the SRAM pins each cycle.
  task automatic do_access(input int vi, input vec_t v);
    int unsigned w, lat;
    logic        st, in_lo, in_hi;
    logic [19:0] e_bus;
    logic [31:0] e_rd;
    w  = (v.dut == 1) ? 1 : 0;
    st = v.wr;
`ifdef SRAM_CTRL_READ_HIT_EN
    lat = v.hit ? 0 : 2 * w + 3;
`else
    lat = 2 * w + 3;
`endif
    if (v.rd && !v.wr) exp_rd[v.dut] = v.rdata;
    sb_q.push_back(exp_rd[v.dut]);
    rd_drv[v.dut] = v.rd; wr_drv[v.dut] = v.wr;
    addr_drv[v.dut] = v.addr; wd_drv[v.dut] = v.wdata;
    for (int unsigned c = 0; c <= lat; c++) begin
      @(negedge clk);
      in_lo = (lat != 0) && (c >= 1) && (c <= w + 1);
      in_hi = (lat != 0) && (c >= w + 2) && (c <= 2 * w + 2);
      e_bus = {c == lat, !(st && (in_lo || in_hi)), st && (in_lo || in_hi),
               in_lo ? {v.addr[17:2], 1'b0} : in_hi ? {v.addr[17:2], 1'b1} : 17'h0};
      check($sformatf("v%0d c%0d rdy/we_n/oe/addr", vi, c),
            64'({rdy[v.dut], swe[v.dut], soe[v.dut], sadr[v.dut]}), 64'(e_bus));
      if (st)
        check($sformatf("v%0d c%0d dq_out", vi, c), 64'(sdo[v.dut]),
              64'(in_lo ? v.wdata[15:0] : in_hi ? v.wdata[31:16] : 16'h0));
      if (c == lat) begin
        if (sb_q.size() == 0) begin
          check($sformatf("v%0d scoreboard empty", vi), 64'(0), 64'(1));
        end else begin
          e_rd = sb_q.pop_front();
          check($sformatf("v%0d read_data", vi), 64'(rdat[v.dut]), 64'(e_rd));
        end
      end
      @(posedge clk); #1;
    end
    rd_drv[v.dut] = 1'b0; wr_drv[v.dut] = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1, 1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{0, 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0,          1'b0};
    vecs[2]  = '{0, 1'b1, 1'b0, 32'h0000_0020, 32'h0,          32'h1234_5678, 1'b0};
    vecs[3]  = '{0, 1'b1, 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 32'h0,          1'b0};
    vecs[4]  = '{0, 1'b1, 1'b0, 32'h0000_0024, 32'h0,          32'hCAFE_F00D, 1'b0};
    vecs[5]  = '{1, 1'b0, 1'b1, 32'hFFFC_0030, 32'hA5A5_5A5A, 32'h0,          1'b0};
    vecs[6]  = '{1, 1'b1, 1'b0, 32'h0000_0033, 32'h0,          32'hA5A5_5A5A, 1'b0};
    vecs[7]  = '{1, 1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{1, 1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 1'b1};
    vecs[9]  = '{1, 1'b0, 1'b1, 32'h0000_0050, 32'h0BAD_C0DE, 32'h0,          1'b0};
    vecs[10] = '{1, 1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 1'b0};

    for (int k = 0; k < 2; k++) begin
      rd_drv[k] = 1'b0; wr_drv[k] = 1'b0; addr_drv[k] = '0; wd_drv[k] = '0;
      exp_rd[k] = '0;
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      check($sformatf("reset state dut%0d", k),
            64'({rdy[k], swe[k], soe[k], sadr[k], sdo[k], rdat[k]}),
            64'({1'b1, 1'b1, 1'b0, 17'h0, 16'h0, 32'h0}));
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vecs[i]) do_access(i, vecs[i]);

    // Idle bus.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        check($sformatf("idle c%0d dut%0d", c, k), 64'({rdy[k], swe[k], soe[k]}), 64'(3'b110));
    end
    @(posedge clk); #1;

    // Reset asserted during the HIGH half of a store on the W=1 instance.
    rd_drv[1] = 1'b0; wr_drv[1] = 1'b1; addr_drv[1] = 32'h0000_0020; wd_drv[1] = 32'h5555_AAAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("store HIGH before reset we_n", 64'(swe[1]), 64'(0));
    #1 rst = 1'b0;
    #1;
    check("reset mid-access pins", 64'({swe[1], soe[1], rdat[1]}), 64'({1'b1, 1'b0, 32'h0}));
    wr_drv[1] = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("after reset ready/addr", 64'({rdy[1], sadr[1]}), 64'({1'b1, 17'h0}));
    @(posedge clk); #1;
    do_access(20, '{1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0});
    do_access(21, '{0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0});

    check("scoreboard drained", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
